cache_refill: RTL and testbench
===============================

CACHE_REFILL -- requirements
Module: cache_refill

Interface
- REQ-001: Parameter LINE_WORDS, default 4, words per cache line; SHALL be a power of two, 1..16.
- REQ-002: Parameter MEM_LAT, default 1, cycles from mem_addr to valid mem_rdata; SHALL be 1..4.
- REQ-003: clk  in  1  single clock; all state SHALL update on its rising edge.
- REQ-004: reset  in  1  synchronous, active-high reset.
- REQ-005: req  in  1  miss request from the CPU, a level held until done.
- REQ-006: req_addr  in  8  missed word address, sampled when req is accepted.
- REQ-007: mem_rdata  in  16  data-memory read data, valid MEM_LAT cycles after mem_addr.
- REQ-008: mem_addr  out  8  data-memory read address.
- REQ-009: cache_we  out  1  cache write strobe, one cycle per word.
- REQ-010: cache_addr  out  8  cache write address.
- REQ-011: cache_wdata  out  16  cache write data.
- REQ-012: busy  out  1  refill in progress.
- REQ-013: done  out  1  one-cycle completion pulse.

Function
- REQ-014: The FSM SHALL have the states IDLE, ISSUE, WAIT, WRITE and DONE.
- REQ-015: In IDLE with req=1, the block SHALL latch req_addr, compute base = req_addr with its low log2(LINE_WORDS) bits cleared, clear the word counter and enter ISSUE.
- REQ-016: ISSUE SHALL drive mem_addr = base + offset and hold busy=1.
  - ISSUE lasts one cycle.
  - offset = (start + count) mod LINE_WORDS; start is defined in REQ-031/032.
- REQ-017: WAIT SHALL last MEM_LAT-1 cycles (none when MEM_LAT=1) and hold mem_addr stable.
- REQ-018: WRITE SHALL last one cycle with cache_we=1, cache_addr = the issued mem_addr, cache_wdata = mem_rdata.
  - The WRITE cycle falls exactly MEM_LAT cycles after its ISSUE cycle.
- REQ-019: After WRITE, if count < LINE_WORDS-1 the block SHALL increment count and return to ISSUE; otherwise it SHALL enter DONE.
- REQ-020: DONE SHALL last one cycle with done=1, busy=0, cache_we=0, then return to IDLE.
- REQ-021: Busy duration SHALL be exactly LINE_WORDS*(MEM_LAT+1) cycles; with defaults, 8 busy cycles, then done on the 9th cycle after acceptance.
- REQ-022: Deasserting req mid-refill SHALL NOT abort the refill; req SHALL be ignored outside IDLE.
- REQ-023: Offset arithmetic SHALL wrap modulo LINE_WORDS, and addresses SHALL never leave the line.
  - Example: a line with base 8'hFC covers FC..FF with no carry.
- REQ-024: When req is still 1 on return to IDLE, the block SHALL accept it as a new request in that cycle.
- REQ-025: Outside ISSUE/WAIT/WRITE, mem_addr SHALL hold its last value, cache_we SHALL be 0, and cache_addr and cache_wdata SHALL hold their last values.

Reset
- REQ-026: With reset=1 at a clock edge, the next state SHALL be IDLE, from any state including mid-refill.
- REQ-027: On reset the outputs SHALL clear: mem_addr=0, cache_we=0, cache_addr=0, cache_wdata=0, busy=0, done=0.
- REQ-028: On reset the latched address and counter SHALL clear to 0.
- REQ-029: A refill cut by reset SHALL produce no further cache_we and no done pulse.
- REQ-030: A req held high through reset release SHALL be accepted on the first edge with reset=0.

Configuration
- REQ-031: With CACHE_REFILL_CRITICAL_FIRST_EN defined, start SHALL equal req_addr mod LINE_WORDS, so the missed word is written first and the fill wraps within the line.
- REQ-032: Without CACHE_REFILL_CRITICAL_FIRST_EN, start SHALL be 0, so the fill runs base..base+LINE_WORDS-1 in order.
- REQ-033: Cycle counts and the done timing SHALL be identical with and without the macro.

Verification
Memory model: mem[a] = 16'hA000 + a.
- REQ-034: Defaults, macro off, req_addr=8'h13.
  - Writes: (10,A010),(11,A011),(12,A012),(13,A013).
  - cache_we is high on cycles 2,4,6,8 after acceptance; done on cycle 9.
- REQ-035: Defaults, macro on, req_addr=8'h13.
  - Write order: 13,10,11,12 with matching data.
  - done is on the same cycle as in REQ-034.
- REQ-036: req_addr=8'hFE, macro on.
  - Writes: FE,FF,FC,FD.
  - No address outside FC..FF.
- REQ-037: reset pulsed after the second cache_we.
  - Next cycle: busy=0, cache_we=0, outputs at 0.
  - No done; a fresh req then restarts at word 0.
- REQ-038: MEM_LAT=3, LINE_WORDS=2, req held high through done.
  - Each write falls 3 cycles after its issue; busy lasts 8 cycles.
  - Second refill is accepted the cycle after done.
- REQ-039: req dropped after one cycle.
  - The refill still completes all LINE_WORDS writes and pulses done exactly once.

Source files
------------

// File: rtl/cache_refill.sv
// cache_refill: fills one cache line from a fixed-latency data memory.
// Each word takes one ISSUE cycle, MEM_LAT-1 WAIT cycles and one WRITE
// cycle, so a line occupies the block for LINE_WORDS*(MEM_LAT+1) cycles,
// followed by a single DONE cycle.
// Optional feature: define CACHE_REFILL_CRITICAL_FIRST_EN to start the fill
// at the missed word and wrap within the line (critical word first);
// otherwise the line is filled from its base address upward.
module cache_refill #(
  parameter int LINE_WORDS = 4,   // words per line, power of two, 1..16
  parameter int MEM_LAT    = 1    // memory read latency in cycles, 1..4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [7:0]  req_addr,
  input  logic [15:0] mem_rdata,
  output logic [7:0]  mem_addr,
  output logic        cache_we,
  output logic [7:0]  cache_addr,
  output logic [15:0] cache_wdata,
  output logic        busy,
  output logic        done
);

  // Low address bits that select a word within the line; also the index of
  // the last word in the line.
  localparam logic [7:0] OFF_MASK  = 8'(LINE_WORDS - 1);
  localparam logic [7:0] LAST_WORD = 8'(LINE_WORDS - 1);
  // Value of the wait counter on the final WAIT cycle (unused when MEM_LAT=1).
  localparam logic [1:0] WAIT_LAST = 2'(MEM_LAT - 2);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    WRITE,
    DONE
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [7:0]  base;       // line base address, low offset bits cleared
  logic [7:0]  start;      // offset of the first word fetched
  logic [7:0]  count;      // words already written in this refill
  logic [1:0]  wait_cnt;   // cycles spent in WAIT for the current word
  logic [15:0] wdata_q;    // last written data, held outside WRITE
  logic [7:0]  req_base;
  logic [7:0]  req_start;

  // Address of the word at position idx of the fill sequence. The offset is
  // wrapped with the mask and OR-ed onto the base, so no carry can ever leave
  // the line (base FC covers FC..FF only).
  function automatic logic [7:0] line_addr(input logic [7:0] line_base,
                                           input logic [7:0] first,
                                           input logic [7:0] idx);
    logic [7:0] off;
    off = (first + idx) & OFF_MASK;
    return line_base | off;
  endfunction

  // Base and starting offset derived from an incoming request address.
  always_comb begin
    req_base = req_addr & ~OFF_MASK;
`ifdef CACHE_REFILL_CRITICAL_FIRST_EN
    req_start = req_addr & OFF_MASK;
`else
    req_start = 8'd0;
`endif
  end

  // State register; reset returns to IDLE from any state.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic and status outputs; req is only looked at in IDLE.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    cache_we   = 1'b0;
    case (state)
      IDLE: begin
        if (req) state_next = ISSUE;
      end
      ISSUE: begin
        busy = 1'b1;
        if (MEM_LAT == 1) state_next = WRITE;
        else              state_next = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (wait_cnt == WAIT_LAST) state_next = WRITE;
      end
      WRITE: begin
        busy     = 1'b1;
        cache_we = 1'b1;
        if (count == LAST_WORD) state_next = DONE;
        else                    state_next = ISSUE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Write data comes straight from memory during WRITE and is held afterwards.
  always_comb begin
    cache_wdata = (state == WRITE) ? mem_rdata : wdata_q;
  end

  // Refill datapath: latch the line, step through its words, hold addresses.
  always_ff @(posedge clk) begin
    if (reset) begin
      base       <= 8'd0;
      start      <= 8'd0;
      count      <= 8'd0;
      wait_cnt   <= 2'd0;
      mem_addr   <= 8'd0;
      cache_addr <= 8'd0;
      wdata_q    <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            base     <= req_base;
            start    <= req_start;
            count    <= 8'd0;
            mem_addr <= line_addr(req_base, req_start, 8'd0);
          end
        end
        ISSUE: begin
          wait_cnt <= 2'd0;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 2'd1;
        end
        WRITE: begin
          wdata_q <= mem_rdata;
          // The final word leaves mem_addr untouched so it holds through DONE.
          if (count != LAST_WORD) begin
            count    <= count + 8'd1;
            mem_addr <= line_addr(base, start, count + 8'd1);
          end
        end
        default: ;
      endcase
      // mem_addr is stable since ISSUE, so it is the address being written.
      if (state_next == WRITE) cache_addr <= mem_addr;
    end
  end

endmodule

// File: tb/tb_cache_refill.sv
// Directed bench for cache_refill: one default instance (LINE_WORDS=4,
// MEM_LAT=1) and one with LINE_WORDS=2, MEM_LAT=3. Memory returns
// 16'hA000 + address after the instance's latency.
module tb_cache_refill;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Default-parameter instance
  logic        d_req;
  logic [7:0]  d_req_addr;
  logic [15:0] d_mem_rdata;
  logic [7:0]  d_mem_addr;
  logic        d_cache_we;
  logic [7:0]  d_cache_addr;
  logic [15:0] d_cache_wdata;
  logic        d_busy;
  logic        d_done;

  // Long-latency, two-word-line instance
  logic        l_req;
  logic [7:0]  l_req_addr;
  logic [15:0] l_mem_rdata;
  logic [7:0]  l_mem_addr;
  logic        l_cache_we;
  logic [7:0]  l_cache_addr;
  logic [15:0] l_cache_wdata;
  logic        l_busy;
  logic        l_done;
  logic [15:0] l_pipe_a;
  logic [15:0] l_pipe_b;

  cache_refill dut_d (
    .clk        (clk),
    .reset      (reset),
    .req        (d_req),
    .req_addr   (d_req_addr),
    .mem_rdata  (d_mem_rdata),
    .mem_addr   (d_mem_addr),
    .cache_we   (d_cache_we),
    .cache_addr (d_cache_addr),
    .cache_wdata(d_cache_wdata),
    .busy       (d_busy),
    .done       (d_done)
  );

  cache_refill #(.LINE_WORDS(2), .MEM_LAT(3)) dut_l (
    .clk        (clk),
    .reset      (reset),
    .req        (l_req),
    .req_addr   (l_req_addr),
    .mem_rdata  (l_mem_rdata),
    .mem_addr   (l_mem_addr),
    .cache_we   (l_cache_we),
    .cache_addr (l_cache_addr),
    .cache_wdata(l_cache_wdata),
    .busy       (l_busy),
    .done       (l_done)
  );

  // Memory models: one-cycle and three-cycle read pipelines.
  always @(posedge clk) begin
    d_mem_rdata <= 16'hA000 + {8'h00, d_mem_addr};
    l_pipe_a    <= 16'hA000 + {8'h00, l_mem_addr};
    l_pipe_b    <= l_pipe_a;
    l_mem_rdata <= l_pipe_b;
  end

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_order [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Idle/reset state of one instance; with_zero also requires cleared addresses/data.
  task automatic check_idle(input string name, input int sel, input bit with_zero);
    check({name, " busy"}, sel ? l_busy : d_busy, 0);
    check({name, " done"}, sel ? l_done : d_done, 0);
    check({name, " we"},   sel ? l_cache_we : d_cache_we, 0);
    if (with_zero) begin
      check({name, " mem_addr"},    sel ? l_mem_addr : d_mem_addr, 0);
      check({name, " cache_addr"},  sel ? l_cache_addr : d_cache_addr, 0);
      check({name, " cache_wdata"}, sel ? l_cache_wdata : d_cache_wdata, 0);
    end
  endtask

  // Follows one refill that is accepted on the next rising edge, checking
  // every cycle against exp_order. Returns at the negedge of the DONE cycle.
  task automatic run_refill(input string name, input int sel, input int lat, input int n,
                            input bit drop_req, input bit hold_req, input bit in_line_fc);
    int total;
    int k;
    int p;
    logic [7:0] a;
    total = n * (lat + 1);
    for (int i = 1; i <= total + 1; i++) begin
      @(negedge clk);
      if (i <= total) begin
        k = (i - 1) / (lat + 1);
        p = (i - 1) % (lat + 1);
        a = exp_order[k];
        check($sformatf("%s c%0d busy", name, i), sel ? l_busy : d_busy, 1);
        check($sformatf("%s c%0d done", name, i), sel ? l_done : d_done, 0);
        check($sformatf("%s c%0d mem_addr", name, i), sel ? l_mem_addr : d_mem_addr, a);
        check($sformatf("%s c%0d we", name, i), sel ? l_cache_we : d_cache_we, (p == lat) ? 1 : 0);
        if (p == lat) begin
          check($sformatf("%s c%0d cache_addr", name, i), sel ? l_cache_addr : d_cache_addr, a);
          check($sformatf("%s c%0d cache_wdata", name, i), sel ? l_cache_wdata : d_cache_wdata,
                {16'h0, 16'hA000 + {8'h00, a}});
        end
      end else begin
        a = exp_order[n - 1];
        check($sformatf("%s c%0d done", name, i), sel ? l_done : d_done, 1);
        check($sformatf("%s c%0d busy", name, i), sel ? l_busy : d_busy, 0);
        check($sformatf("%s c%0d we", name, i), sel ? l_cache_we : d_cache_we, 0);
        check($sformatf("%s c%0d hold mem_addr", name, i), sel ? l_mem_addr : d_mem_addr, a);
        check($sformatf("%s c%0d hold cache_addr", name, i), sel ? l_cache_addr : d_cache_addr, a);
        check($sformatf("%s c%0d hold wdata", name, i), sel ? l_cache_wdata : d_cache_wdata,
              {16'h0, 16'hA000 + {8'h00, a}});
      end
      if (in_line_fc)
        check($sformatf("%s c%0d in line", name, i), {26'h0, d_mem_addr[7:2]}, 32'h3F);
      if ((drop_req && i == 1) || (!hold_req && i == total + 1)) begin
        if (sel) l_req = 1'b0;
        else     d_req = 1'b0;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    d_req = 1'b0; d_req_addr = 8'h00;
    l_req = 1'b0; l_req_addr = 8'h00;
    repeat (3) @(negedge clk);
    check_idle("reset d", 0, 1);
    check_idle("reset l", 1, 1);

    // Line 10..13, miss on 13, req held until done
    reset = 1'b0;
    d_req = 1'b1; d_req_addr = 8'h13;
`ifdef CACHE_REFILL_CRITICAL_FIRST_EN
    exp_order[0] = 8'h13; exp_order[1] = 8'h10; exp_order[2] = 8'h11; exp_order[3] = 8'h12;
`else
    exp_order[0] = 8'h10; exp_order[1] = 8'h11; exp_order[2] = 8'h12; exp_order[3] = 8'h13;
`endif
    run_refill("fill13", 0, 1, 4, 0, 0, 0);
    @(negedge clk);
    check_idle("after fill13", 0, 0);

    // Top line FC..FF, miss on FE, req dropped after one cycle
    d_req = 1'b1; d_req_addr = 8'hFE;
`ifdef CACHE_REFILL_CRITICAL_FIRST_EN
    exp_order[0] = 8'hFE; exp_order[1] = 8'hFF; exp_order[2] = 8'hFC; exp_order[3] = 8'hFD;
`else
    exp_order[0] = 8'hFC; exp_order[1] = 8'hFD; exp_order[2] = 8'hFE; exp_order[3] = 8'hFF;
`endif
    run_refill("fillFE", 0, 1, 4, 1, 0, 1);
    repeat (2) @(negedge clk);
    check_idle("after fillFE", 0, 0);

    // Reset after the second write, req held high through reset release
    d_req = 1'b1; d_req_addr = 8'h13;
    repeat (3) @(negedge clk);
    @(negedge clk);
    check("pre-reset second we", d_cache_we, 1);
    reset = 1'b1;
    d_req = 1'b0;
    @(negedge clk);
    check_idle("cut by reset", 0, 1);
    d_req = 1'b1;
    @(negedge clk);
    check_idle("req in reset", 0, 1);
    reset = 1'b0;
`ifdef CACHE_REFILL_CRITICAL_FIRST_EN
    exp_order[0] = 8'h13; exp_order[1] = 8'h10; exp_order[2] = 8'h11; exp_order[3] = 8'h12;
`else
    exp_order[0] = 8'h10; exp_order[1] = 8'h11; exp_order[2] = 8'h12; exp_order[3] = 8'h13;
`endif
    run_refill("restart", 0, 1, 4, 0, 0, 0);
    @(negedge clk);
    check_idle("after restart", 0, 0);

    // MEM_LAT=3, two-word line 12..13, req held through done: back-to-back
    l_req = 1'b1; l_req_addr = 8'h13;
`ifdef CACHE_REFILL_CRITICAL_FIRST_EN
    exp_order[0] = 8'h13; exp_order[1] = 8'h12;
`else
    exp_order[0] = 8'h12; exp_order[1] = 8'h13;
`endif
    run_refill("lat3 a", 1, 3, 2, 0, 1, 0);
    @(negedge clk);
    check("lat3 idle busy", l_busy, 0);
    check("lat3 idle done", l_done, 0);
    run_refill("lat3 b", 1, 3, 2, 1, 0, 0);
    repeat (2) @(negedge clk);
    check_idle("after lat3", 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
